// File: rtl/ps_mem_responder.sv
// Terminal ps_if responder: local word RAM with write-done pulses and an in-order, backpressured read-response buffer.
// Optional macro PS_MEM_RESPONDER_NODE_FILTER_EN restricts service to requests whose node_addr equals NODE_ID.
module ps_mem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 8,
  parameter int NODE_ADDR_WIDTH = 4,
  parameter int NODE_ID         = 0,
  parameter int RESP_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  input  logic                       wvalid,
  output logic                       wready,
  output logic                       wresp,
  input  logic [ADDR_WIDTH-1:0]      raddr,
  input  logic                       arvalid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rvalid,
  input  logic                       rready,
  input  logic [NODE_ADDR_WIDTH-1:0] node_addr,
  output logic                       rd_overflow
);

  localparam int PTR_W = $clog2(RESP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] ram      [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] fifo_mem [0:RESP_DEPTH-1];

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  wresp_q, wresp_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic                  match;
  logic                  wr_en;
  logic                  has_space;
  logic                  rd_accept;
  logic                  rd_drop;
  logic                  fifo_empty;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  push;
  logic                  fifo_pop;

`ifdef PS_MEM_RESPONDER_NODE_FILTER_EN
  assign match = (node_addr == NODE_ADDR_WIDTH'(NODE_ID));
`else
  logic unused_node;
  assign match       = 1'b1;
  assign unused_node = ^node_addr;
`endif

  always_comb begin
    wr_en      = wvalid && !rst && match;
    // Space is counted over buffered entries plus the RAM read still in flight.
    has_space  = (count_q + CNT_W'(inflight_q)) < CNT_W'(RESP_DEPTH);
    rd_accept  = arvalid && match && !rst && has_space;
    rd_drop    = arvalid && match && !rst && !has_space;
    fifo_empty = (count_q == '0);
    out_valid  = !fifo_empty || inflight_q;
    out_data   = fifo_empty ? rd_data_q : fifo_mem[rd_ptr_q];
    // A fresh RAM result presented directly and taken this cycle never enters the buffer.
    push       = inflight_q && !(fifo_empty && rready);
    fifo_pop   = !fifo_empty && rready;

    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(fifo_pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
    inflight_d = rd_accept;
    wresp_d    = wr_en;
    ovf_d      = ovf_q || rd_drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      wresp_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      wresp_q    <= wresp_d;
      ovf_q      <= ovf_d;
    end
  end

  // RAM is never cleared; a same-address write forwards its data to the read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[waddr] <= wdata;
    end
    if (rd_accept) begin
      rd_data_q <= (wr_en && (waddr == raddr)) ? wdata : ram[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= rd_data_q;
    end
  end

  // Outputs are forced low while rst is high so a pending pulse cannot leak into the reset cycle.
  assign wready      = !rst;
  assign wresp       = wresp_q && !rst;
  assign rvalid      = out_valid && !rst;
  assign rdata       = rvalid ? out_data : '0;
  assign rd_overflow = ovf_q && !rst;

endmodule

// File: tb/tb_ps_mem_responder.sv
// Bench for ps_mem_responder: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based model of the responder.
module tb_ps_mem_responder;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int NW  = 4;
  localparam int NID = 0;
  localparam int RD  = 4;
`ifdef PS_MEM_RESPONDER_NODE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic          wresp;
  logic [AW-1:0] raddr = '0;
  logic          arvalid = 1'b0;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [NW-1:0] node_addr = NW'(NID);
  logic          rd_overflow;

  ps_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NODE_ADDR_WIDTH(NW), .NODE_ID(NID), .RESP_DEPTH(RD)
  ) dut (
    .clk(clk), .rst(rst), .waddr(waddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .wresp(wresp), .raddr(raddr), .arvalid(arvalid), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .node_addr(node_addr), .rd_overflow(rd_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mem_m [0:(2**AW)-1];
  logic [DW-1:0] rq [$];
  bit            wresp_e = 1'b0;
  bit            ovf_e   = 1'b0;
  int            m_sz;
  bit            m_match;
  bit            m_wacc;
  logic [DW-1:0] m_tmp;

  function automatic bit node_ok(input logic [NW-1:0] n);
    return FILT ? (n == NW'(NID)) : 1'b1;
  endfunction

  // Every response owed (computed at acceptance) sits in rq and is visible the next cycle.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      rq.delete();
      wresp_e = 1'b0;
      ovf_e   = 1'b0;
    end else begin
      m_sz    = rq.size();
      m_match = node_ok(node_addr);
      m_wacc  = wvalid && m_match;
      if (m_sz > 0 && rready) m_tmp = rq.pop_front();
      if (arvalid && m_match) begin
        if (m_sz < RD) rq.push_back((m_wacc && waddr == raddr) ? wdata : mem_m[raddr]);
        else ovf_e = 1'b1;
      end
      if (m_wacc) mem_m[waddr] = wdata;
      wresp_e = m_wacc;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit exp_rv;
  initial forever begin
    @(negedge clk);
    exp_rv = !rst && (rq.size() > 0);
    chk("wready", DW'(wready), DW'(!rst));
    chk("wresp", DW'(wresp), DW'(!rst && wresp_e));
    chk("rvalid", DW'(rvalid), DW'(exp_rv));
    chk("rd_overflow", DW'(rd_overflow), DW'(!rst && ovf_e));
    if (exp_rv) begin
      if (!$isunknown(rq[0])) chk("rdata", rdata, rq[0]);
    end else if (rst) begin
      chk("rdata_rst", rdata, '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_pct;

  initial begin
    // Reset: two cycles
    step();
    chk("rst_wready", DW'(wready), 0);
    chk("rst_wresp", DW'(wresp), 0);
    chk("rst_rvalid", DW'(rvalid), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ovf", DW'(rd_overflow), 0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_wready", DW'(wready), 1);

    // Write then read
    wvalid = 1'b1; waddr = 8'h05; wdata = 32'hDEADBEEF; node_addr = NW'(NID);
    step();
    wvalid = 1'b0;
    chk("t1_wresp", DW'(wresp), 1);
    step();
    chk("t1_wresp_single", DW'(wresp), 0);
    arvalid = 1'b1; raddr = 8'h05; rready = 1'b1;
    step();
    arvalid = 1'b0;
    chk("t1_rvalid", DW'(rvalid), 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    step();
    chk("t1_rvalid_drop", DW'(rvalid), 0);

    // Preload every address, back-to-back writes
    for (int a = 0; a < 2**AW; a++) begin
      wvalid = 1'b1; waddr = AW'(a);
      wdata = (a < 4) ? (32'hA0 + DW'(a)) : (32'hC000_0000 | DW'(a));
      step();
    end
    wvalid = 1'b0;
    chk("preload_last_wresp", DW'(wresp), 1);
    step();

    // Node filter
    node_addr = NW'(NID + 1);
    wvalid = 1'b1; waddr = 8'h07; wdata = 32'h12345678;
    step();
    wvalid = 1'b0; node_addr = NW'(NID);
    chk("nf_wresp", DW'(wresp), DW'(!FILT));
    arvalid = 1'b1; raddr = 8'h07; rready = 1'b1;
    step();
    arvalid = 1'b0;
    chk("nf_rvalid", DW'(rvalid), 1);
    chk("nf_rdata", rdata, FILT ? 32'hC000_0007 : 32'h12345678);
    step();
    node_addr = NW'(NID + 1); arvalid = 1'b1; raddr = 8'h07;
    step();
    arvalid = 1'b0; node_addr = NW'(NID);
    chk("nf_offnode_rvalid", DW'(rvalid), DW'(!FILT));
    step();

    // Collision: write-first bypass
    wvalid = 1'b1; waddr = 8'h10; wdata = 32'h55;
    arvalid = 1'b1; raddr = 8'h10; rready = 1'b1;
    step();
    wvalid = 1'b0; arvalid = 1'b0;
    chk("col_rvalid", DW'(rvalid), 1);
    chk("col_rdata", rdata, 32'h55);
    chk("col_wresp", DW'(wresp), 1);
    step();

    // Streaming 16 reads
    rready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      arvalid = 1'b1; raddr = AW'(i);
      step();
      chk($sformatf("stream_rvalid_%0d", i), DW'(rvalid), 1);
    end
    arvalid = 1'b0;
    chk("stream_last_rdata", rdata, 32'hC000_000F);
    step();
    chk("stream_end_rvalid", DW'(rvalid), 0);
    chk("stream_ovf", DW'(rd_overflow), 0);

    // Backpressure and overflow
    rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      arvalid = 1'b1; raddr = AW'(i);
      step();
    end
    chk("bp_rvalid", DW'(rvalid), 1);
    chk("bp_head", rdata, 32'hA0);
    chk("bp_ovf_before", DW'(rd_overflow), 0);
    raddr = 8'h04;
    step();
    arvalid = 1'b0;
    chk("bp_ovf_after", DW'(rd_overflow), 1);
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_drain_rvalid_%0d", i), DW'(rvalid), 1);
      chk($sformatf("bp_drain_rdata_%0d", i), rdata, 32'hA0 + DW'(i));
      step();
    end
    chk("bp_empty", DW'(rvalid), 0);

    // Reset mid-operation
    rready = 1'b0;
    for (int i = 8; i < 11; i++) begin
      arvalid = 1'b1; raddr = AW'(i);
      step();
    end
    arvalid = 1'b0;
    wvalid = 1'b1; waddr = 8'h20; wdata = 32'h77;
    step();
    wvalid = 1'b0;
    chk("mid_rvalid_pre", DW'(rvalid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rvalid", DW'(rvalid), 0);
    chk("mid_rst_ovf", DW'(rd_overflow), 0);
    chk("mid_rst_wresp", DW'(wresp), 0);
    chk("mid_rst_wready", DW'(wready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mid_post_rvalid", DW'(rvalid), 0);
    chk("mid_post_ovf", DW'(rd_overflow), 0);
    arvalid = 1'b1; raddr = 8'h20; rready = 1'b1;
    step();
    chk("mid_wr_before_rst", rdata, 32'h77);
    raddr = 8'h08;
    step();
    arvalid = 1'b0;
    chk("mid_readback", rdata, 32'hC000_0008);
    step();

    // Randomized traffic
    rr_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) rr_pct = $urandom_range(10, 100);
      rst       = ($urandom_range(0, 299) == 0);
      wvalid    = $urandom_range(0, 1) == 1;
      waddr     = AW'($urandom_range(0, 31));
      wdata     = $urandom;
      arvalid   = $urandom_range(0, 3) != 0;
      raddr     = AW'($urandom_range(0, 31));
      rready    = $urandom_range(1, 100) <= rr_pct;
      node_addr = ($urandom_range(0, 3) == 0) ? NW'(NID + 1) : NW'(NID);
      step();
    end
    rst = 1'b0; wvalid = 1'b0; arvalid = 1'b0; rready = 1'b1;
    repeat (8) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
